// File: rtl/io_load_sequencer.sv
// ============================================================================
// Module   : io_load_sequencer
// Brief    : Streams a counted run of input words into parameter memory
//            starting at a latched base address, with abort and error pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_load_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_one = ADDR_WIDTH'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_next_count;

  assign in_ready     = (r_state == LOAD) && !abort;
  assign busy         = (r_state != IDLE);
  assign w_xfer       = in_valid && in_ready;
  assign w_next_count = word_count + c_one;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_base     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      done       <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;

      // The write lands one cycle after acceptance; address wraps naturally.
      if (w_xfer) begin
        mem_we     <= 1'b1;
        mem_addr   <= r_base + word_count;
        mem_wdata  <= in_data;
        word_count <= w_next_count;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_len      <= length;
            r_base     <= base_addr;
            word_count <= '0;
            r_state    <= (length == '0) ? FINISH : LOAD;
          end
        end
        LOAD: begin
          if (start)
            start_err <= 1'b1;
          if (abort)
            r_state <= IDLE;
          else if (w_xfer && (w_next_count == r_len))
            r_state <= FINISH;
        end
        FINISH: begin
          if (start)
            start_err <= 1'b1;
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/io_load_sequencer.md
IO_LOAD_SEQUENCER -- requirements
Module: io_load_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning input/memory word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning memory address, length and word-count width.
REQ-003 The block SHALL have port CLK, input, 1, meaning the single clock, all state updating on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning request to load length words starting at base_addr.
REQ-006 The block SHALL have port length, input, ADDR_WIDTH, meaning number of words to load, sampled on accepted start.
REQ-007 The block SHALL have port base_addr, input, ADDR_WIDTH, meaning first write address, sampled on accepted start.
REQ-008 The block SHALL have port abort, input, 1, meaning cancel an in-progress load.
REQ-009 The block SHALL have port in_valid, input, 1, meaning in_data holds a word.
REQ-010 The block SHALL have port in_data, input, DATA_WIDTH, meaning incoming word.
REQ-011 The block SHALL have port in_ready, output, 1, meaning block accepts a word this cycle.
REQ-012 The block SHALL have port mem_we, output, 1, meaning write strobe to parameter memory.
REQ-013 The block SHALL have port mem_addr, output, ADDR_WIDTH, meaning write address.
REQ-014 The block SHALL have port mem_wdata, output, DATA_WIDTH, meaning write data.
REQ-015 The block SHALL have port word_count, output, ADDR_WIDTH, meaning words accepted in the current or last load.
REQ-016 The block SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-017 The block SHALL have port done, output, 1, meaning one-cycle pulse on normal completion.
REQ-018 The block SHALL have port start_err, output, 1, meaning one-cycle pulse when start arrives while busy.

Function
REQ-019 The block SHALL implement states IDLE, LOAD and FINISH; busy = (state != IDLE).
REQ-020 In IDLE, start=1 with length>0 SHALL latch length and base_addr, clear word_count to 0 and enter LOAD next cycle.
REQ-021 In IDLE, start=1 with length=0 SHALL clear word_count and enter FINISH next cycle with no memory write.
REQ-022 in_ready SHALL be 1 exactly when state is LOAD and abort=0 (combinational from state and abort).
REQ-023 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; in_valid without in_ready SHALL have no effect.
REQ-024 On a transfer, the next cycle SHALL show mem_we=1, mem_addr=(base_addr+word_count_before) mod 2^ADDR_WIDTH, mem_wdata=in_data, and word_count SHALL be incremented; latency accept-to-write is exactly 1 cycle.
REQ-025 mem_we SHALL be 0 on every cycle not directly following a transfer; mem_addr and mem_wdata SHALL hold their last value otherwise.
REQ-026 The transfer that makes word_count equal latched length SHALL move state to FINISH next cycle (same cycle as that final mem_we).
REQ-027 In FINISH the block SHALL return to IDLE next cycle with done=1 for exactly that one cycle, i.e. done follows the last mem_we by one cycle.
REQ-028 abort=1 in LOAD SHALL block any transfer that cycle, return to IDLE next cycle, keep word_count, and never produce done; a write from the previous cycle's transfer still completes.
REQ-029 abort in IDLE or FINISH SHALL be ignored.
REQ-030 start while busy SHALL be ignored for loading and SHALL pulse start_err for one cycle next cycle; latched length/base_addr SHALL be unchanged.
REQ-031 Address wrap SHALL be modulo 2^ADDR_WIDTH (base 0xFE, 3 words -> 0xFE, 0xFF, 0x00).
REQ-032 Back-to-back loads SHALL be possible: start accepted in the cycle done is high (state IDLE).

Reset
REQ-033 RST=1 SHALL immediately, without CLK, force state IDLE and in_ready=0, mem_we=0, done=0, start_err=0, busy=0, mem_addr=0, mem_wdata=0, word_count=0.
REQ-034 Reset mid-load SHALL discard the load with no done and no further writes after release.

Verification
REQ-035 base_addr=0x10, length=3, in_valid held 1, data A,B,C -> mem_we at 0x10,0x11,0x12 on 3 consecutive cycles, done one cycle after last write, word_count=3.
REQ-036 length=0 start -> no mem_we, done pulses 2 cycles after start, word_count=0.
REQ-037 base_addr=0xFE, length=3, in_valid toggling 1,0,1,0,1 -> writes to 0xFE,0xFF,0x00 only on cycles after valid, done after third.
REQ-038 length=5, abort asserted after 2 transfers -> 2 writes, busy drops next cycle, no done, word_count=2.
REQ-039 start pulsed during LOAD -> start_err one cycle, original load completes unchanged.
REQ-040 RST asserted asynchronously mid-load at word 1 of 4 -> all outputs zero immediately, no done or writes after release.
